// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/execute memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EX_BUSY = 2'd1,
        IF_BUSY = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and an execute port onto one single-ported memory,
// favouring execute but bounding how long fetch can be starved.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              ex_req,
    input  logic              ex_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_ack,
    output logic [DATA_W-1:0] ex_rdata,
    output logic              ex_stall,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_e             state_q,     state_d;
    owner_e             owner_q,     owner_d;
    logic               dir_q,       dir_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  wdata_q,     wdata_d;
    logic [CNT_W-1:0]   starve_q,    starve_d;
    logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]  ex_rdata_q,  ex_rdata_d;
    logic [DATA_W-1:0]  cap_data;

    logic               if_ack_q,    if_ack_d;
    logic               ex_ack_q,    ex_ack_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            dir_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            ex_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            ex_ack_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dir_q       <= dir_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            ex_rdata_q  <= ex_rdata_d;
            if_ack_q    <= if_ack_d;
            ex_ack_q    <= ex_ack_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state: arbitrate in IDLE, wait for mem_ready in BUSY, ack once in RESP.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        ex_rdata_d = ex_rdata_q;
        cap_data   = dir_q ? '0 : mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (ex_req && (!if_req || (starve_q < CNT_MAX))) begin
                    state_d = EX_BUSY;
                    owner_d = OWN_EX;
                    dir_d   = ex_write;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != CNT_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (if_req) begin
                    state_d  = IF_BUSY;
                    owner_d  = OWN_IF;
                    dir_d    = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            EX_BUSY, IF_BUSY: begin
                if (mem_ready) begin
                    state_d = RESP;
                    if (owner_q == OWN_EX) begin
                        ex_rdata_d = cap_data;
                    end else begin
                        if_rdata_d = cap_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        if_ack_d    = 1'b0;
        ex_ack_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        if ((state_d == EX_BUSY) || (state_d == IF_BUSY)) begin
            mem_read_d  = ~dir_d;
            mem_write_d = dir_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end else if (state_d == RESP) begin
            if_ack_d = (owner_d == OWN_IF);
            ex_ack_d = (owner_d == OWN_EX);
        end
    end

    assign if_ack    = if_ack_q;
    assign ex_ack    = ex_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ex_rdata  = ex_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_stall  = if_req & ~if_ack_q;
    assign ex_stall  = ex_req & ~ex_ack_q;

endmodule
